instr_fetch: RTL and testbench

- Fetch stage of the 8-bit processor.
- Holds the program counter and runs a request/acknowledge handshake with instruction memory.
- Captures each 8-bit instruction in an instruction register.
- Presents the 3-bit opcode (instruction bits [7:5]) to the control unit and the full word to the datapath, one instruction at a time, with a downstream stall.

---
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 8-bit processor.
// Holds the program counter, fetches one instruction word at a time from
// instruction memory over a req/ack handshake, and presents it downstream
// together with its opcode until it is consumed.
// Optional feature macro: IFETCH_ILLEGAL_HALT_EN (halt after an illegal
// instruction has been consumed; leave only via rst).
//
// Handshake semantics:
//   Memory side: imem_req is high in every FETCH cycle with imem_addr=pc.
//   A transfer happens on a rising edge where imem_req=1 and imem_ack=1;
//   the memory may ack in the same cycle req rises, and may see req drop
//   without an ack when rst is asserted. imem_ack outside FETCH is ignored.
//   Downstream side: instr/opcode are offered while instr_valid=1. The
//   instruction is consumed on a rising edge with instr_valid=1 and
//   stall=0; stall has no effect while instr_valid=0.
module instr_fetch #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [7:0]          imem_data,
  input  logic                stall,
  output logic [7:0]          instr,
  output logic [2:0]          opcode,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                illegal,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
`ifdef IFETCH_ILLEGAL_HALT_EN
  localparam logic [1:0] ST_HALT  = 2'd2;
`endif

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          instr_q, instr_d;
  logic                illegal_op;

  // Opcodes 001, 010 and 011 are not defined for this processor.
  always_comb begin
    illegal_op = (instr_q[7:5] == 3'b001) ||
                 (instr_q[7:5] == 3'b010) ||
                 (instr_q[7:5] == 3'b011);
  end

  // Next-state, next-pc and instruction-capture logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          pc_d    = pc_q + PC_WIDTH'(1);  // wraps modulo 2^PC_WIDTH
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
`ifdef IFETCH_ILLEGAL_HALT_EN
          state_d = illegal_op ? ST_HALT : ST_FETCH;
`else
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef IFETCH_ILLEGAL_HALT_EN
      ST_HALT: begin
        state_d = ST_HALT;  // frozen until rst
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Output decode; req is masked during reset so an outstanding request
  // is dropped immediately.
  always_comb begin
    imem_req    = (state_q == ST_FETCH) && !rst;
    imem_addr   = pc_q;
    instr       = instr_q;
    opcode      = instr_q[7:5];
    instr_valid = (state_q == ST_ISSUE);
    illegal     = (state_q == ST_ISSUE) && illegal_op;
    pc          = pc_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch (PC_WIDTH=8, RESET_PC=8'h10).
// A memory responder with per-address wait states, a behavioural model of
// the fetch stage, a per-cycle compare process and directed literal checks.
module tb_instr_fetch;

  localparam logic [7:0] RST_PC = 8'h10;

  logic       clk;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       stall;
  logic [7:0] instr;
  logic [2:0] opcode;
  logic       instr_valid;
  logic [7:0] pc;
  logic       illegal;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit compare_en = 0;

  instr_fetch #(.PC_WIDTH(8), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .illegal(illegal), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  logic [7:0] mem [256];
  int         delay [256];
  int         wait_cnt;

  assign imem_ack  = imem_req && (wait_cnt >= delay[imem_addr]);
  assign imem_data = mem[imem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // ---------------- behavioural model ----------------
  // have: an instruction has been captured and not yet consumed.
  bit         m_have, m_halt;
  logic [7:0] m_pc, m_instr;
  logic [7:0] exp_q[$];

  function automatic bit is_illegal(input logic [7:0] w);
    int op;
    op = int'(w[7:5]);
    return (op >= 1) && (op <= 3);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have  <= 1'b0;
      m_halt  <= 1'b0;
      m_pc    <= RST_PC;
      m_instr <= 8'h00;
      exp_q.delete();
    end else if (!m_halt) begin
      if (!m_have) begin
        if (imem_ack) begin
          m_have  <= 1'b1;
          m_instr <= mem[m_pc];
          m_pc    <= m_pc + 8'd1;
          exp_q.push_back(mem[m_pc]);
        end
      end else if (!stall) begin
        m_have <= 1'b0;
`ifdef IFETCH_ILLEGAL_HALT_EN
        if (is_illegal(m_instr)) m_halt <= 1'b1;
`endif
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid low phase.
  always @(negedge clk) begin
    #3;
    if (compare_en) begin
      check("cmp_req", 32'(imem_req), 32'(!rst && !m_have && !m_halt));
      if (!rst && !m_have && !m_halt) check("cmp_addr", 32'(imem_addr), 32'(m_pc));
      check("cmp_valid", 32'(instr_valid), 32'(m_have));
      check("cmp_pc", 32'(pc), 32'(m_pc));
      check("cmp_instr", 32'(instr), 32'(m_instr));
      check("cmp_opcode", 32'(opcode), 32'(m_instr >> 5));
      check("cmp_illegal", 32'(illegal), 32'(m_have && is_illegal(m_instr)));
      if (instr_valid && !stall && !rst) begin
        if (exp_q.size() == 0) begin
          check("consume_unexpected", 32'(instr), 32'hFFFF_FFFF);
        end else begin
          check("consume_word", 32'(instr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [7:0] a);
    int n;
    n = 0;
    while (!(imem_req && imem_addr == a) && n < 2000) begin
      step();
      n++;
    end
    check("wait_addr_timeout", 32'(imem_req && imem_addr == a), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'h80;
      delay[i] = 0;
    end
    mem[8'h10] = 8'h00;
    mem[8'h11] = 8'h9F;
    mem[8'h12] = 8'hC3;
    mem[8'h06] = 8'h20;
    delay[8'h05] = 3;

    step();
    check("rst_req_low", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    step();
    rst = 1'b0;
    compare_en = 1'b1;
    #1;
    // reset state after release
    check("rel_req", 32'(imem_req), 32'd1);
    check("rel_addr", 32'(imem_addr), 32'h10);
    check("rel_valid", 32'(instr_valid), 32'd0);
    check("rel_instr", 32'(instr), 32'h00);
    check("rel_illegal", 32'(illegal), 32'd0);

    // zero-wait fetch of 0x10 and 0x11
    step();
    check("f10_valid", 32'(instr_valid), 32'd1);
    check("f10_opcode", 32'(opcode), 32'd0);
    check("f10_pc", 32'(pc), 32'h11);
    step();
    check("f11_req", 32'(imem_req), 32'd1);
    check("f11_addr", 32'(imem_addr), 32'h11);
    check("f11_valid_gap", 32'(instr_valid), 32'd0);
    step();
    check("f11_valid", 32'(instr_valid), 32'd1);
    check("f11_opcode", 32'(opcode), 32'd4);
    check("f11_instr", 32'(instr), 32'h9F);
    check("f11_pc", 32'(pc), 32'h12);

    // stall for 4 cycles on 0xC3; stall raised during FETCH has no effect
    step();
    check("f12_addr", 32'(imem_addr), 32'h12);
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", 32'(instr), 32'hC3);
      check("stall_opcode", 32'(opcode), 32'd6);
      check("stall_no_req", 32'(imem_req), 32'd0);
      if (i == 5) stall = 1'b0;
    end
    step();
    check("post_stall_valid", 32'(instr_valid), 32'd0);
    check("post_stall_addr", 32'(imem_addr), 32'h13);

    // pc wrap at 0xFF
    wait_addr(8'hFF);
    step();
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_valid", 32'(instr_valid), 32'd1);
    step();
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr", 32'(imem_addr), 32'h00);

    // three wait states at 0x05
    wait_addr(8'h05);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr5", 32'(imem_addr), 32'h05);
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    step();
    check("wait_cap_valid", 32'(instr_valid), 32'd1);
    check("wait_cap_instr", 32'(instr), 32'h80);
    check("wait_cap_pc", 32'(pc), 32'h06);

    // illegal opcode 001 at 0x06
    step();
    check("ill_fetch_addr", 32'(imem_addr), 32'h06);
    step();
    check("ill_instr", 32'(instr), 32'h20);
    check("ill_opcode", 32'(opcode), 32'd1);
    check("ill_flag", 32'(illegal), 32'd1);
`ifdef IFETCH_ILLEGAL_HALT_EN
    for (int i = 0; i < 5; i++) begin
      step();
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_illegal", 32'(illegal), 32'd0);
      check("halt_pc", 32'(pc), 32'h07);
    end
`else
    step();
    check("ill_next_req", 32'(imem_req), 32'd1);
    check("ill_next_addr", 32'(imem_addr), 32'h07);
    check("ill_cleared", 32'(illegal), 32'd0);
`endif

    // asynchronous reset during a stalled ISSUE
    rst = 1'b1;
    step();
    rst   = 1'b0;
    stall = 1'b1;
    #1;
    check("rs_addr", 32'(imem_addr), 32'h10);
    step();
    check("rs_issue_valid", 32'(instr_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_pc", 32'(pc), 32'h10);
    check("async_instr", 32'(instr), 32'h00);
    check("async_illegal", 32'(illegal), 32'd0);
    step();
    rst   = 1'b0;
    #1;
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'h10);
    stall = 1'b0;
    step();
    check("restart_valid", 32'(instr_valid), 32'd1);
    check("restart_instr", 32'(instr), 32'h00);
    repeat (4) step();

    compare_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
